// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU op encodings, sequencer op codes and FSM state type for the MULTU/DIVU sequencer.
package alu_muldiv_seq_pkg;

    // ALU control is {select[2:0], c_in}
    localparam logic [3:0] AluPassA = 4'b0000;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0101;

    // ALU function selects
    localparam logic [2:0] SelPassA = 3'b000;
    localparam logic [2:0] SelAdd   = 3'b001;
    localparam logic [2:0] SelSub   = 3'b010;
    localparam logic [2:0] SelAnd   = 3'b011;
    localparam logic [2:0] SelOr    = 3'b100;
    localparam logic [2:0] SelXor   = 3'b101;
    localparam logic [2:0] SelNor   = 3'b110;

    // Sequencer operation codes
    localparam logic MdMultu = 1'b0;
    localparam logic MdDivu  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } md_state_e;

    // Shift-add multiply adds the multiplicand only when the current multiplier bit is set
    function automatic logic [3:0] mul_step_op(input logic mq_lsb);
        return mq_lsb ? AluAdd : AluPassA;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Small combinational ALU; output carries one extra bit for carry / no-borrow.
module alu_muldiv_seq_alu
    import alu_muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH:0]   y_o
);

    logic [2:0]     sel;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] b_inv_ext;
    logic [WIDTH:0] cin_ext;

    assign sel       = op_i[3:1];
    assign a_ext     = {1'b0, a_i};
    assign b_ext     = {1'b0, b_i};
    assign b_inv_ext = {1'b0, ~b_i};
    assign cin_ext   = {{WIDTH{1'b0}}, op_i[0]};

    // Function decode; SUB is a + ~b + c_in so y[WIDTH] is the no-borrow flag
    always_comb begin
        y_o = '0;
        case (sel)
            SelPassA: y_o = a_ext + cin_ext;
            SelAdd:   y_o = a_ext + b_ext + cin_ext;
            SelSub:   y_o = a_ext + b_inv_ext + cin_ext;
            SelAnd:   y_o = {1'b0, a_i & b_i};
            SelOr:    y_o = {1'b0, a_i | b_i};
            SelXor:   y_o = {1'b0, a_i ^ b_i};
            SelNor:   y_o = {1'b0, ~(a_i | b_i)};
            default:  y_o = b_ext;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// One-bit-per-cycle unsigned MULTU/DIVU sequencer returning MIPS HI/LO results.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;     // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, hi_d;   // acc (MULTU) or remainder R (DIVU)
    logic [WIDTH-1:0] lo_q, lo_d;   // mq (MULTU) or quotient Q (DIVU)
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_a;
    logic [3:0]       alu_op;
    logic [WIDTH:0]   alu_y;
    logic [WIDTH:0]   rs;
    logic             ge;

    // Partial remainder shifted left with the next dividend bit
    assign rs = {hi_q, lo_q[WIDTH-1]};

    alu_muldiv_seq_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a_i (alu_a),
        .b_i (b_q),
        .op_i(alu_op),
        .y_o (alu_y)
    );

    // ALU operand/op selection for the current step
    always_comb begin
        alu_a  = hi_q;
        alu_op = AluPassA;
        if (op_q == MdDivu) begin
            alu_a  = rs[WIDTH-1:0];
            alu_op = AluSub;
        end else begin
            alu_op = mul_step_op(lo_q[0]);
        end
    end

    // rs[WIDTH] set means the shifted remainder already exceeds any divisor
    assign ge = rs[WIDTH] | alu_y[WIDTH];

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        div_by_zero = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StRun;
                    op_d    = op;
                    b_d     = opb;
                    hi_d    = '0;
                    lo_d    = opa;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (op_q == MdDivu) begin
                    hi_d = ge ? alu_y[WIDTH-1:0] : rs[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ge};
                end else begin
                    // Carry-out lands in acc MSB, the ALU LSB shifts into mq
                    hi_d = alu_y[WIDTH:1];
                    lo_d = {alu_y[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CntLast) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                out_valid   = 1'b1;
                div_by_zero = (op_q == MdDivu) && (b_q == '0);
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign result_hi = hi_q;
    assign result_lo = lo_q;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= MdMultu;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq (WIDTH=8): directed vectors, stall, reset, random ops.
module tb_alu_muldiv_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    alu_muldiv_seq #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ehi, output logic [W-1:0] elo,
                         output logic edz);
        int unsigned ua, ub, p;
        ua = a;
        ub = b;
        edz = 1'b0;
        if (o == 1'b0) begin
            p   = ua * ub;
            ehi = W'(p >> W);
            elo = W'(p);
        end else if (ub == 0) begin
            ehi = a;
            elo = '1;
            edz = 1'b1;
        end else begin
            ehi = W'(ua % ub);
            elo = W'(ua / ub);
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz, input int stall);
        int lat;
        @(negedge clk);
        check({tag, " idle in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op       = o;
        opa      = a;
        opb      = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 1'($urandom);
        opa      = W'($urandom);
        opb      = W'($urandom);
        check({tag, " run out_valid"}, out_valid, 0);
        check({tag, " run in_ready"}, in_ready, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, W);
        check({tag, " hi"}, result_hi, ehi);
        check({tag, " lo"}, result_lo, elo);
        check({tag, " dbz"}, div_by_zero, edz);
        check({tag, " hold in_ready"}, in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            op       = 1'($urandom);
            opa      = W'($urandom);
            opb      = W'($urandom);
            @(negedge clk);
            check({tag, " stall out_valid"}, out_valid, 1);
            check({tag, " stall hi"}, result_hi, ehi);
            check({tag, " stall lo"}, result_lo, elo);
            check({tag, " stall dbz"}, div_by_zero, edz);
            check({tag, " stall in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " done out_valid"}, out_valid, 0);
        check({tag, " done in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ehi, elo, ra, rb;
        logic         edz, ro;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset hi", result_hi, 0);
        check("reset lo", result_lo, 0);
        check("reset dbz", div_by_zero, 0);

        run_op("mul 13*11",   1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 0);
        run_op("mul 255*255", 1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 0);
        run_op("mul 0*200",   1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 0);
        run_op("div 200/7",   1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 0);
        run_op("div 255/1",   1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 0);
        run_op("div 130/129", 1'b1, 8'd130, 8'd129, 8'h01, 8'h01, 1'b0, 0);
        run_op("div 77/0",    1'b1, 8'd77,  8'd0,   8'h4D, 8'hFF, 1'b1, 0);
        run_op("mul 9*0",     1'b0, 8'd9,   8'd0,   8'h00, 8'h00, 1'b0, 0);

        // Consumer stalls 5 cycles while a new request is offered
        run_op("stall div",   1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 5);
        run_op("after stall", 1'b0, 8'd3,   8'd5,   8'h00, 8'h0F, 1'b0, 0);

        // Reset during the third RUN cycle
        @(negedge clk);
        in_valid = 1'b1;
        op       = 1'b0;
        opa      = 8'd9;
        opb      = 8'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun reset in_ready", in_ready, 1);
        check("midrun reset out_valid", out_valid, 0);
        check("midrun reset hi", result_hi, 0);
        check("midrun reset lo", result_lo, 0);
        check("midrun reset dbz", div_by_zero, 0);
        run_op("mul 6*7", 1'b0, 8'd6, 8'd7, 8'h00, 8'h2A, 1'b0, 0);

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 24; n++) begin
            ro = 1'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            model(ro, ra, rb, ehi, elo, edz);
            run_op("random", ro, ra, rb, ehi, elo, edz, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
